// File: rtl/debounce_pkg.sv
// Shared definitions for the multi-channel debouncer: per-channel FSM
// state encoding, used by the channel FSM and by anything observing it.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_t;

    // The debounced level is high only once a press has been accepted.
    function automatic logic state_level(input db_state_t st);
        return (st == PRESSED) || (st == RELEASE_WAIT);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debouncer channel: 2-flop synchroniser, Moore FSM with a stability
// counter, registered press/release strobes and (with LONG_PRESS_EN defined)
// a hold counter driving a one-shot long-press strobe.
//
// Handshake: none. p_raw is a free-running asynchronous level; the strobes are
// single-cycle, unacknowledged events that downstream logic samples every clk.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int CNT_W         = 16,
    parameter int STABLE_CYCLES = 50000,
    parameter int LONG_CYCLES   = 65535
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       p_raw,
    output logic       level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic [1:0] dbg_state
);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             sync_1;
    logic             s;
    db_state_t        state;
    db_state_t        state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             press_next;
    logic             release_next;

    // Two-flop synchroniser; the FSM only ever looks at s.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_1 <= 1'b0;
            s      <= 1'b0;
        end else begin
            sync_1 <= p_raw;
            s      <= sync_1;
        end
    end

    // State, stability counter and registered strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            press_pulse   <= press_next;
            release_pulse <= release_next;
        end
    end

    // Next state: a change is accepted only after STABLE_CYCLES equal samples.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        press_next   = 1'b0;
        release_next = 1'b0;
        case (state)
            IDLE: begin
                if (s) begin
                    state_next = PRESS_WAIT;
                    cnt_next   = CNT_W'(1);
                end else begin
                    cnt_next = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                    press_next = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_next = RELEASE_WAIT;
                    cnt_next   = CNT_W'(1);
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_next   = IDLE;
                    cnt_next     = '0;
                    release_next = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign level     = state_level(state);
    assign dbg_state = state;

`ifdef LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES);

    logic [CNT_W-1:0] hold_cnt;
    logic             long_fired;

    // Hold counter: restarts on every entry to PRESSED, saturates at
    // LONG_CYCLES, and fires long_pulse once per press until back in IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_cnt   <= '0;
            long_fired <= 1'b0;
            long_pulse <= 1'b0;
        end else begin
            long_pulse <= 1'b0;
            if (state_next == PRESSED && state != PRESSED) begin
                hold_cnt <= '0;
            end else if (level && hold_cnt != LONG_LAST) begin
                hold_cnt <= hold_cnt + CNT_W'(1);
                if ((hold_cnt + CNT_W'(1)) == LONG_LAST && !long_fired) begin
                    long_pulse <= 1'b1;
                    long_fired <= 1'b1;
                end
            end
            if (state == IDLE) begin
                long_fired <= 1'b0;
            end
        end
    end
`else
    // No hold counter in this build; LONG_CYCLES has no effect.
    assign long_pulse = (LONG_CYCLES < 0);
`endif

endmodule

// File: rtl/multi_channel_debouncer.sv
// N-channel push-button debouncer: N_CH independent debounce_channel
// instances. Build option: define LONG_PRESS_EN to include the long-press
// strobe; otherwise long_pulse is constant 0.
// dbg_state packs each channel's 2-bit FSM state (channel i at [2*i +: 2]).
module multi_channel_debouncer
    import debounce_pkg::*;
#(
    parameter int N_CH          = 4,
    parameter int CNT_W         = 16,
    parameter int STABLE_CYCLES = 50000,
    parameter int LONG_CYCLES   = 65535
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_CH-1:0]   p_raw,
    output logic [N_CH-1:0]   level,
    output logic [N_CH-1:0]   press_pulse,
    output logic [N_CH-1:0]   release_pulse,
    output logic [N_CH-1:0]   long_pulse,
    output logic [2*N_CH-1:0] dbg_state
);

    // One fully independent debouncer per channel.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .CNT_W        (CNT_W),
            .STABLE_CYCLES(STABLE_CYCLES),
            .LONG_CYCLES  (LONG_CYCLES)
        ) u_ch (
            .clk          (clk),
            .reset        (reset),
            .p_raw        (p_raw[i]),
            .level        (level[i]),
            .press_pulse  (press_pulse[i]),
            .release_pulse(release_pulse[i]),
            .long_pulse   (long_pulse[i]),
            .dbg_state    (dbg_state[2*i +: 2])
        );
    end

endmodule
